// File: rtl/io_bus_bridge_pkg.sv
// Shared constants for the IO-page bridge: FSM state codes, IO page select bit, abort read data.
package io_bus_bridge_pkg;

  localparam logic [1:0] IO_ST_IDLE = 2'd0;
  localparam logic [1:0] IO_ST_RD   = 2'd1;
  localparam logic [1:0] IO_ST_WR   = 2'd2;

  localparam int unsigned IO_PAGE_BIT_DFLT = 22;
  localparam logic [31:0] IO_ERR_DATA      = 32'hDEADBEEF;

endpackage

// File: rtl/io_bus_bridge_if.sv
// CPU-side memory bus plus external io_* request port seen by the bridge.
// slave = bridge view, master = CPU/far-end view.
interface io_bus_bridge_if;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;

  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        io_valid;
  logic        io_ready;
  logic [31:0] io_rdata;
  logic        io_err;

  modport slave (
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb, io_ready, io_rdata,
    output mem_rdata, mem_rbusy, mem_wbusy, io_addr, io_wdata, io_wstrb, io_valid, io_err
  );

  modport master (
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb, io_ready, io_rdata,
    input  mem_rdata, mem_rbusy, mem_wbusy, io_addr, io_wdata, io_wstrb, io_valid, io_err
  );

endinterface

// File: rtl/io_bridge_timer.sv
// Saturating wait-cycle counter for the bridge; expired flags the last allowed wait cycle.
module io_bridge_timer #(
  parameter int unsigned TO_W        = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] LastWait = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!RESET || clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // count_q holds completed wait cycles, so the current cycle is number count_q+1.
  assign expired = enable && (count_q == LastWait);

endmodule

// File: rtl/io_bus_bridge.sv
// Turns FemtoRV32 single-cycle IO-page strobes into a held io_valid/io_ready request.
// Optional abort-on-timeout is enabled by defining IO_BRIDGE_TIMEOUT_EN.
module io_bus_bridge
  import io_bus_bridge_pkg::*;
#(
  parameter int unsigned IO_PAGE_BIT = IO_PAGE_BIT_DFLT
`ifdef IO_BRIDGE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8,
  parameter logic [31:0] ERR_DATA    = IO_ERR_DATA
`endif
) (
  input logic            clk,
  input logic            RESET,
  io_bus_bridge_if.slave bus
);

  logic [1:0]  state_q;
  logic        wr_req;
  logic        rd_req;
  logic        launch;
  logic        expired;
  logic [31:0] cpl_data;

  // A write strobe takes priority over a simultaneous read strobe.
  assign wr_req = (state_q == IO_ST_IDLE) && bus.mem_addr[IO_PAGE_BIT] && (bus.mem_wmask != 4'b0);
  assign rd_req = (state_q == IO_ST_IDLE) && bus.mem_addr[IO_PAGE_BIT] && bus.mem_rstrb && !wr_req;
  assign launch = wr_req || rd_req;

`ifdef IO_BRIDGE_TIMEOUT_EN
  io_bridge_timer #(
    .TO_W        (TO_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .RESET   (RESET),
    .clear   (launch),
    .enable  (state_q != IO_ST_IDLE),
    .expired (expired)
  );

  assign cpl_data = bus.io_ready ? bus.io_rdata : ERR_DATA;

  always_ff @(posedge clk) begin
    if (!RESET) begin
      bus.io_err <= 1'b0;
    end else if (expired && !bus.io_ready) begin
      bus.io_err <= 1'b1;
    end
  end
`else
  assign expired    = 1'b0;
  assign cpl_data   = bus.io_rdata;
  assign bus.io_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q       <= IO_ST_IDLE;
      bus.io_addr   <= 32'h0;
      bus.io_wdata  <= 32'h0;
      bus.io_wstrb  <= 4'b0;
      bus.io_valid  <= 1'b0;
      bus.mem_rbusy <= 1'b0;
      bus.mem_wbusy <= 1'b0;
      bus.mem_rdata <= 32'h0;
    end else begin
      case (state_q)
        IO_ST_IDLE: begin
          if (launch) begin
            bus.io_addr   <= bus.mem_addr & 32'hFFFF_FFFC;
            bus.io_wdata  <= bus.mem_wdata;
            bus.io_wstrb  <= wr_req ? bus.mem_wmask : 4'b0;
            bus.io_valid  <= 1'b1;
            bus.mem_rbusy <= rd_req;
            bus.mem_wbusy <= wr_req;
            state_q       <= wr_req ? IO_ST_WR : IO_ST_RD;
          end
        end
        IO_ST_RD, IO_ST_WR: begin
          if (bus.io_ready || expired) begin
            bus.io_valid  <= 1'b0;
            bus.mem_rbusy <= 1'b0;
            bus.mem_wbusy <= 1'b0;
            state_q       <= IO_ST_IDLE;
            if (state_q == IO_ST_RD) begin
              bus.mem_rdata <= cpl_data;
            end
          end
        end
        default: state_q <= IO_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed, table-driven bench for io_bus_bridge with hand-written reset/back-to-back/timeout cases.
module tb_io_bus_bridge;

`ifdef IO_BRIDGE_TIMEOUT_EN
  localparam int WrWait = 2;
`else
  localparam int WrWait = 4;
`endif

  typedef struct {
    string       name;
    logic        rstrb;
    logic [3:0]  wmask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        launch;
    logic        exp_wr;
    logic [3:0]  exp_wstrb;
    int          exp_busy;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk;
  logic RESET;
  int   errors;
  int   checks;
  int   rises;
  logic valid_prev;

  io_bus_bridge_if bus ();

  io_bus_bridge #(
    .IO_PAGE_BIT (22)
`ifdef IO_BRIDGE_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (4)
`endif
  ) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.io_valid && !valid_prev) rises <= rises + 1;
    valid_prev <= bus.io_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    step();
    bus.mem_addr  = v.addr;
    bus.mem_wdata = v.wdata;
    bus.mem_wmask = v.wmask;
    bus.mem_rstrb = v.rstrb;
    bus.io_rdata  = v.rdata;
    bus.io_ready  = !v.launch;  // ready while idle must be ignored
    step();
    bus.mem_wmask = 4'b0;
    bus.mem_rstrb = 1'b0;
    bus.mem_addr  = 32'h0040_0FF0;
    bus.mem_wdata = 32'hFFFF_FFFF;
    if (!v.launch) begin
      repeat (2) begin
        check({v.name, ".idle_valid"}, {31'b0, bus.io_valid}, 32'h0);
        check({v.name, ".idle_busy"}, {30'b0, bus.mem_rbusy, bus.mem_wbusy}, 32'h0);
        step();
      end
      bus.io_ready = 1'b0;
      check({v.name, ".rdata"}, bus.mem_rdata, v.exp_rdata);
      return;
    end
    check({v.name, ".valid"}, {31'b0, bus.io_valid}, 32'h1);
    check({v.name, ".rbusy"}, {31'b0, bus.mem_rbusy}, {31'b0, !v.exp_wr});
    check({v.name, ".wbusy"}, {31'b0, bus.mem_wbusy}, {31'b0, v.exp_wr});
    n = 0;
    while ((bus.mem_rbusy || bus.mem_wbusy) && n < 64) begin
      n++;
      check({v.name, ".io_addr"}, bus.io_addr, v.exp_addr);
      check({v.name, ".io_wdata"}, bus.io_wdata, v.wdata);
      check({v.name, ".io_wstrb"}, {28'b0, bus.io_wstrb}, {28'b0, v.exp_wstrb});
      bus.io_ready = (n > v.delay);
      step();
    end
    bus.io_ready = 1'b0;
    check({v.name, ".busy_cycles"}, n, v.exp_busy);
    check({v.name, ".valid_done"}, {31'b0, bus.io_valid}, 32'h0);
    check({v.name, ".rdata"}, bus.mem_rdata, v.exp_rdata);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".valid"}, {31'b0, bus.io_valid}, 32'h0);
    check({name, ".wstrb"}, {28'b0, bus.io_wstrb}, 32'h0);
    check({name, ".busy"}, {30'b0, bus.mem_rbusy, bus.mem_wbusy}, 32'h0);
    check({name, ".rdata"}, bus.mem_rdata, 32'h0);
    check({name, ".err"}, {31'b0, bus.io_err}, 32'h0);
  endtask

  vec_t vecs[6];
  vec_t v;

  initial begin
    errors = 0;
    checks = 0;
    rises  = 0;
    valid_prev = 1'b0;
    vecs[0] = '{"rd0", 1'b1, 4'h0, 32'h0040_0004, 32'h0, 32'h1234_5678, 0, 1'b1, 1'b0,
                4'h0, 1, 32'h0040_0004, 32'h1234_5678};
    vecs[1] = '{"wr_wait", 1'b0, 4'b0011, 32'h0040_0008, 32'hA5A5_00FF, 32'h0, WrWait, 1'b1,
                1'b1, 4'b0011, WrWait + 1, 32'h0040_0008, 32'h1234_5678};
    vecs[2] = '{"rd_nonio", 1'b1, 4'h0, 32'h0000_0100, 32'h0, 32'h9999_9999, 0, 1'b0, 1'b0,
                4'h0, 0, 32'h0, 32'h1234_5678};
    vecs[3] = '{"rdwr", 1'b1, 4'hF, 32'h0040_000C, 32'h1122_3344, 32'hCAFE_F00D, 1, 1'b1, 1'b1,
                4'hF, 2, 32'h0040_000C, 32'h1234_5678};
    vecs[4] = '{"rd_unal", 1'b1, 4'h0, 32'h00C0_0013, 32'h77, 32'h0BAD_F00D, 2, 1'b1, 1'b0,
                4'h0, 3, 32'h00C0_0010, 32'h0BAD_F00D};
    vecs[5] = '{"wr_nonio", 1'b0, 4'hF, 32'h0000_0200, 32'h1, 32'h0, 0, 1'b0, 1'b0,
                4'h0, 0, 32'h0, 32'h0BAD_F00D};

    RESET = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wmask = 4'h0;
    bus.mem_rstrb = 1'b0;
    bus.io_ready  = 1'b0;
    bus.io_rdata  = 32'h0;
    repeat (3) step();
    check_reset_outputs("por");
    RESET = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset while a read is waiting on the far end.
    step();
    bus.mem_addr  = 32'h0040_0020;
    bus.mem_rstrb = 1'b1;
    step();
    bus.mem_rstrb = 1'b0;
    check("midrd.rbusy", {31'b0, bus.mem_rbusy}, 32'h1);
    step();
    RESET = 1'b0;
    repeat (3) step();
    check_reset_outputs("midrd");
    RESET = 1'b1;
    v = '{"post_rst", 1'b1, 4'h0, 32'h0040_0024, 32'h0, 32'h55AA_55AA, 0, 1'b1, 1'b0,
          4'h0, 1, 32'h0040_0024, 32'h55AA_55AA};
    run_vec(v);

    // Back-to-back: read strobe in the idle cycle right after a write completes.
    step();
    rises = 0;
    bus.mem_addr  = 32'h0040_0030;
    bus.mem_wdata = 32'h0000_BEEF;
    bus.mem_wmask = 4'b1000;
    bus.io_ready  = 1'b1;
    step();
    bus.mem_wmask = 4'b0;
    check("b2b.wbusy", {31'b0, bus.mem_wbusy}, 32'h1);
    step();
    check("b2b.wdone", {30'b0, bus.io_valid, bus.mem_wbusy}, 32'h0);
    bus.mem_addr  = 32'h0040_0040;
    bus.mem_rstrb = 1'b1;
    bus.io_rdata  = 32'h600D_CAFE;
    step();
    bus.mem_rstrb = 1'b0;
    check("b2b.rvalid", {30'b0, bus.io_valid, bus.mem_rbusy}, 32'h3);
    check("b2b.raddr", bus.io_addr, 32'h0040_0040);
    check("b2b.rwstrb", {28'b0, bus.io_wstrb}, 32'h0);
    step();
    bus.io_ready = 1'b0;
    check("b2b.rdone", {30'b0, bus.io_valid, bus.mem_rbusy}, 32'h0);
    check("b2b.rdata", bus.mem_rdata, 32'h600D_CAFE);
    step();
    check("b2b.pulses", rises, 2);

`ifdef IO_BRIDGE_TIMEOUT_EN
    v = '{"tmo", 1'b1, 4'h0, 32'h0040_0050, 32'h0, 32'h1111_2222, 1000, 1'b1, 1'b0,
          4'h0, 4, 32'h0040_0050, 32'hDEAD_BEEF};
    run_vec(v);
    check("tmo.err", {31'b0, bus.io_err}, 32'h1);
    repeat (3) step();
    check("tmo.err_sticky", {31'b0, bus.io_err}, 32'h1);
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    check("tmo.err_rst", {31'b0, bus.io_err}, 32'h0);
    v = '{"tmo_rdy", 1'b1, 4'h0, 32'h0040_0054, 32'h0, 32'h3333_4444, 3, 1'b1, 1'b0,
          4'h0, 4, 32'h0040_0054, 32'h3333_4444};
    run_vec(v);
    check("tmo_rdy.err", {31'b0, bus.io_err}, 32'h0);
`else
    check("noerr", {31'b0, bus.io_err}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
